// File: rtl/leb128_encoder.sv
// leb128_encoder
// Serialises one typed wasm value into its bytecode immediate byte stream.
// Integers (i32/i64) become signed LEB128, floats (f32/f64) become raw
// little-endian IEEE bytes, as in the *.const immediates.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      synchronous, active-high
//   in_valid   value offered on in_data/in_type
//   in_ready   encoder can accept a value (only while idle)
//   in_data    64-bit value; i32/f32 use [31:0]
//   in_type    value type code (0 i32, 1 i64, 2 f32, 3 f64, matching cpu.vh)
//   out_valid  out_data holds a byte
//   out_ready  sink accepts the byte this cycle
//   out_data   encoded byte
//   out_last   final byte of the current value
//   out_count  bytes emitted for the last completed value
//
// Build option: define RESULT_TAG_EN to prefix every value with its wasm
// valtype byte (0x7F i32, 0x7E i64, 0x7D f32, 0x7C f64). The tag is counted
// in out_count.
//
// States
//   IDLE | waiting for a value, in_ready high
//   TAG  | valtype byte presented (RESULT_TAG_EN builds only)
//   EMIT | payload byte presented, waiting for the sink

module leb128_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [1:0]  in_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [3:0]  out_count
);

    localparam logic [1:0] T_I32 = 2'd0;
    localparam logic [1:0] T_I64 = 2'd1;
    localparam logic [1:0] T_F32 = 2'd2;
    localparam logic [1:0] T_F64 = 2'd3;

`ifdef RESULT_TAG_EN
    localparam logic [3:0] TAG_BYTES = 4'd1;
    typedef enum logic [1:0] {IDLE, EMIT, TAG} state_t;
`else
    localparam logic [3:0] TAG_BYTES = 4'd0;
    typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

    state_t      state, state_d;
    logic [63:0] val, val_d;          // value bits not yet emitted
    logic [1:0]  val_type, val_type_d;
    logic [3:0]  pay_cnt, pay_d;      // payload bytes presented so far
    logic [7:0]  data_d;
    logic        last_d, valid_d, ready_d;
    logic [3:0]  count_d;

    // encoder datapath shared by the first byte (from in_data) and later ones
    logic [63:0] v_in;
    logic [63:0] src;
    logic [1:0]  src_type;
    logic [3:0]  pay_nxt;
    logic [63:0] enc_rest;
    logic [7:0]  enc_byte;
    logic        enc_done;
    logic        is_float;

    always_comb begin
        unique case (in_type)
            T_I32:   v_in = {{32{in_data[31]}}, in_data[31:0]};
            T_F32:   v_in = {32'd0, in_data[31:0]};
            default: v_in = in_data;
        endcase
    end

    always_comb begin
        src      = val;
        src_type = val_type;
        pay_nxt  = (pay_cnt == 4'd10) ? pay_cnt : pay_cnt + 4'd1;
        if (state == IDLE) begin
            src      = v_in;
            src_type = in_type;
            pay_nxt  = 4'd1;
        end
`ifdef RESULT_TAG_EN
        else if (state == TAG) begin
            pay_nxt = 4'd1;
        end
`endif
    end

    always_comb begin
        is_float = (src_type == T_F32) || (src_type == T_F64);
        if (is_float) begin
            enc_rest = src >> 8;
            enc_done = (pay_nxt == ((src_type == T_F64) ? 4'd8 : 4'd4));
            enc_byte = src[7:0];
        end else begin
            enc_rest = $signed(src) >>> 7;
            // stop once the remaining bits are pure sign extension of b[6]
            enc_done = ((enc_rest == 64'd0) && !src[6]) ||
                       ((enc_rest == {64{1'b1}}) && src[6]);
            enc_byte = {~enc_done, src[6:0]};
        end
    end

    always_comb begin
        state_d    = state;
        val_d      = val;
        val_type_d = val_type;
        pay_d      = pay_cnt;
        data_d     = out_data;
        last_d     = out_last;
        valid_d    = out_valid;
        ready_d    = in_ready;
        count_d    = out_count;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    val_type_d = in_type;
                    ready_d    = 1'b0;
                    valid_d    = 1'b1;
`ifdef RESULT_TAG_EN
                    val_d   = v_in;
                    pay_d   = 4'd0;
                    last_d  = 1'b0;
                    state_d = TAG;
                    unique case (in_type)
                        T_I32:   data_d = 8'h7F;
                        T_I64:   data_d = 8'h7E;
                        T_F32:   data_d = 8'h7D;
                        default: data_d = 8'h7C;
                    endcase
`else
                    val_d   = enc_rest;
                    pay_d   = pay_nxt;
                    data_d  = enc_byte;
                    last_d  = enc_done;
                    state_d = EMIT;
`endif
                end
            end
`ifdef RESULT_TAG_EN
            TAG: begin
                if (out_ready) begin
                    val_d   = enc_rest;
                    pay_d   = pay_nxt;
                    data_d  = enc_byte;
                    last_d  = enc_done;
                    state_d = EMIT;
                end
            end
`endif
            EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        count_d = pay_cnt + TAG_BYTES;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = 8'h00;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        val_d  = enc_rest;
                        pay_d  = pay_nxt;
                        data_d = enc_byte;
                        last_d = enc_done;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            val       <= 64'd0;
            val_type  <= T_I32;
            pay_cnt   <= 4'd0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_count <= 4'd0;
        end else begin
            state     <= state_d;
            val       <= val_d;
            val_type  <= val_type_d;
            pay_cnt   <= pay_d;
            out_data  <= data_d;
            out_last  <= last_d;
            out_valid <= valid_d;
            in_ready  <= ready_d;
            out_count <= count_d;
        end
    end

endmodule

// File: tb/tb_leb128_encoder.sv
// Testbench for leb128_encoder: directed spec vectors plus random values
// with random sink backpressure, checked against a reference encoder.
module tb_leb128_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_type;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [3:0]  out_count;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef RESULT_TAG_EN
    localparam int TAG_N = 1;
`else
    localparam int TAG_N = 0;
`endif

    logic [7:0] exp_q[$];

    leb128_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_type   (in_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: type 0 i32, 1 i64, 2 f32, 3 f64
    function automatic void build_expected(input logic [1:0] t, input logic [63:0] d);
        longint v;
        int     b;
        bit     fin;
        exp_q.delete();
        if (TAG_N == 1) exp_q.push_back(8'(8'h7F - {6'd0, t}));
        if (t == 2'd2 || t == 2'd3) begin
            for (int i = 0; i < ((t == 2'd3) ? 8 : 4); i++)
                exp_q.push_back(8'((d >> (8 * i)) & 64'hFF));
        end else begin
            if (t == 2'd0) v = longint'(int'(d[31:0]));
            else           v = longint'(d);
            fin = 1'b0;
            while (!fin) begin
                b   = int'(v & 64'sd127);
                v   = v >>> 7;
                fin = (v == 0 && (b & 64) == 0) || (v == -1 && (b & 64) != 0);
                exp_q.push_back(fin ? 8'(b) : 8'(b | 128));
            end
        end
    endfunction

    // mode 0: always ready, 1: random ready, 2: three stall cycles after first payload byte
    task automatic run_value(input logic [1:0] t, input logic [63:0] d,
                             input int mode, input bit busy_garbage);
        int         n, idx, stall, guard;
        bit         held, rdy;
        logic [7:0] held_data;
        logic       held_last;
        build_expected(t, d);
        n = exp_q.size();
        idx = 0; stall = 0; held = 0; held_data = 8'h00; held_last = 1'b0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_value", in_ready, 1);
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        @(negedge clk);
        check("first_byte_latency", out_valid, 1);
        in_valid = busy_garbage;
        in_type  = 2'($urandom);
        in_data  = {$urandom, $urandom};
        guard = 0;
        while (idx < n && guard < 400) begin
            check("busy_in_ready_low", in_ready, 0);
            check("busy_out_valid", out_valid, 1);
            if (held) begin
                check("stall_hold_data", out_data, held_data);
                check("stall_hold_last", out_last, held_last);
            end
            if (mode == 2 && idx == TAG_N + 1 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else if (mode == 1) rdy = 1'($urandom);
            else rdy = 1'b1;
            out_ready = rdy;
            if (rdy) begin
                check("byte", out_data, exp_q[idx]);
                check("last_flag", out_last, (idx == n - 1));
                if (idx == n - 1) in_valid = 1'b0;
                idx++;
                held = 0;
            end else begin
                held = 1;
                held_data = out_data;
                held_last = out_last;
            end
            @(negedge clk);
            guard++;
        end
        check("stream_complete", idx, n);
        out_ready = 1'($urandom);
        check("out_count", out_count, n);
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
    endtask

    initial begin
        logic [1:0]  rt;
        logic [63:0] rd;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_type   = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_count", out_count, 0);
        reset = 1'b0;
        @(negedge clk);

        run_value(2'd1, 64'd1, 0, 0);
        run_value(2'd0, 64'd624485, 0, 0);
        run_value(2'd0, 64'hFFFF_FFFF_FFFF_FFC0, 0, 0);   // -64
        run_value(2'd0, 64'hDEAD_BEEF_0000_0040, 0, 1);   // 64, junk upper bits
        run_value(2'd1, 64'h8000_0000_0000_0000, 0, 0);
        run_value(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_value(2'd0, 64'h0000_0000_8000_0000, 0, 0);   // i32 min, 5 bytes
        run_value(2'd2, 64'hA5A5_5A5A_3F80_0000, 0, 0);
        run_value(2'd3, 64'h3FF0_0000_0000_0000, 0, 1);
        run_value(2'd0, 64'd624485, 2, 0);

        // reset while the second byte of i64 min is presented
        in_valid = 1'b1;
        in_type  = 2'd1;
        in_data  = 64'h8000_0000_0000_0000;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_last", out_last, 0);
        check("midreset_out_count", out_count, 0);
        run_value(2'd1, 64'd5, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rt = 2'($urandom);
            rd = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) rd = ~rd;
            run_value(rt, rd, 1, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
